johnson8_monitor: RTL
=====================

# johnson8_monitor

Receive-side checker for the 8-step Johnson sequencer. Samples the sequencer's 4-bit ring state and its 8 decoded phase strobes, encodes them back to a 3-bit phase index, and verifies every transition against the expected Johnson order. It maintains a lock state and counts sequence faults, so silicon bring-up can observe sequencer health on a few pins.

## Interface
- LOCK_COUNT, default 4: consecutive good transitions required to enter LOCKED (1..15).
- ERR_W, default 8: width of saturating error counter.
- CLK  in  1  single clock, same domain as the sequencer.
- RESET  in  1  synchronous, active-high.
- DFF4  in  4  sequencer ring state, bit0 = first stage.
- Decoded8  in  8  sequencer one-hot phase strobes.
- HOLD  in  1  1 = sequencer not advancing this cycle (expect same phase).
- ERR_CLR  in  1  synchronous clear of ERR_COUNT.
- PHASE  out  3  encoded phase index of last checked sample.
- PHASE_VALID  out  1  PHASE comes from a legal sample.
- LOCKED  out  1  monitor is locked to the sequence.
- ERR  out  1  one-cycle fault pulse.
- ERR_CODE  out  2  00 none, 01 illegal state, 10 strobe mismatch, 11 skip/out-of-order.
- ERR_COUNT  out  ERR_W  faults seen while LOCKED, saturating.
- WRAP  out  1  one-cycle pulse on a 7 -> 0 advance while LOCKED.

## Operation
- Legal DFF4 -> phase map: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7. The other 8 codes are illegal.
- Stage 1: DFF4, Decoded8, HOLD are registered every cycle (s_dff, s_dec, s_hold).
- Classify the s-sample in priority order:
  - ILLEGAL (01): s_dff not in the map.
  - MISMATCH (10): s_dec != (1 << phase(s_dff)). This also covers all-zero and multi-hot strobes.
  - Otherwise LEGAL.
- Transition check applies only when the previous sample was LEGAL and the current sample is LEGAL.
  - expected = prev_phase + (prev_hold ? 0 : 1), mod 8 (3-bit wrap).
  - phase != expected -> SKIP (11).
- FSM states ACQUIRE and LOCKED. Reset state is ACQUIRE with good_cnt = 0.
  - ACQUIRE, good transition: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED and clear good_cnt.
  - ACQUIRE, fault of any class, or current sample LEGAL with no legal predecessor: good_cnt = 0, stay in ACQUIRE.
  - LOCKED, good transition: stay.
  - LOCKED, any fault: go to ACQUIRE, good_cnt = 0, ERR_COUNT++ (saturates at all-ones).
- ERR and ERR_CODE report faults in both states. ERR_COUNT counts only faults detected while LOCKED.
- WRAP pulses only on a LOCKED good transition with prev_phase = 7, phase = 0, prev_hold = 0.
- ERR_CLR together with a counted fault in the same cycle: clear wins, ERR_COUNT = 0.
- PHASE updates only on LEGAL samples. On a fault it holds its last value and PHASE_VALID = 0.

## Timing
- Latency: inputs at edge t are sampled; PHASE, PHASE_VALID, LOCKED, ERR, ERR_CODE, WRAP, ERR_COUNT reflect that sample after edge t+1 (2 edges, input to output).
- ERR and WRAP are high for exactly one cycle per event. ERR_CODE is valid only while ERR = 1, and is 00 otherwise.
- Reset values, all outputs: PHASE 0, PHASE_VALID 0, LOCKED 0, ERR 0, ERR_CODE 00, ERR_COUNT 0, WRAP 0.
- Reset also clears the stage-1 registers and the "previous legal" flag.
- The first sample after RESET deasserts is never transition-checked.
- RESET mid-operation: on the next edge, all state returns to reset values regardless of ERR_CLR or the inputs.
- Sequencer held in its own reset (DFF4 = 0000, Decoded8 = 0) classifies as MISMATCH every cycle. This is expected and yields ACQUIRE, never LOCKED.
- Minimum lock time from a clean stream: 1 + LOCK_COUNT samples. The LOCKED output rises LOCK_COUNT + 2 edges after the first legal sample is presented.

## Test plan
- Clean stream, HOLD = 0, phases 0..7 repeating from reset: LOCKED rises after the 4th good transition; WRAP pulses once per 8 cycles; ERR never asserts; ERR_COUNT = 0.
- Once locked, drive DFF4 = 0101 for one cycle: ERR = 1 with ERR_CODE = 01; LOCKED falls the same cycle; ERR_COUNT = 1; PHASE holds; relock after 4 further good transitions.
- Once locked, drive legal DFF4 = 0011 with Decoded8 = 8'h0C: ERR_CODE = 10, ERR_COUNT increments. Then drive Decoded8 = 8'h00 with DFF4 = 0000: ERR_CODE = 10 again.
- Once locked at phase 3, present phase 5 with HOLD = 0: ERR_CODE = 11. Separately, HOLD = 1 then the same phase repeated: no error, and WRAP is suppressed across a held 7.
- Force 2^ERR_W + 3 locked faults: ERR_COUNT saturates at 255. Assert ERR_CLR in the same cycle as a fault: ERR_COUNT = 0.
- Assert RESET mid-stream while LOCKED with ERR_COUNT = 5: all outputs at reset values one edge later. The first post-reset sample produces no ERR.

Source files
------------

// File: rtl/johnson8_monitor.sv
// johnson8_monitor
// Receive-side health checker for an 8-step Johnson sequencer.
// It registers the ring state and phase strobes, then encodes them to a phase index.
// Each sample is checked against the expected Johnson order.
// It reports lock state, one-cycle fault pulses with a class code, and a saturating fault count.
module johnson8_monitor #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       DFF4,
    input  logic [7:0]       Decoded8,
    input  logic             HOLD,
    input  logic             ERR_CLR,
    output logic [2:0]       PHASE,
    output logic             PHASE_VALID,
    output logic             LOCKED,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic             WRAP
);

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCK    = 1'b1
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CODE_MISMATCH = 2'b10;
    localparam logic [1:0] CODE_SKIP     = 2'b11;

    // Stage-1 sample registers; s_valid_q marks that a real post-reset sample is held
    logic             s_valid_q, s_valid_d;
    logic [3:0]       s_dff_q, s_dff_d;
    logic [7:0]       s_dec_q, s_dec_d;
    logic             s_hold_q, s_hold_d;
    logic             s_clr_q, s_clr_d;

    // Checker state and registered outputs
    state_t           state_q, state_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic             prev_legal_q, prev_legal_d;
    logic [2:0]       prev_phase_q, prev_phase_d;
    logic             prev_hold_q, prev_hold_d;
    logic [2:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             wrap_q, wrap_d;

    logic [2:0]       s_phase;
    logic             s_in_map;
    logic             s_legal;
    logic [2:0]       expected_phase;
    logic             good_step;
    logic             fault;
    logic [1:0]       code;

    // Map the registered ring state back to a phase index; 8 of 16 codes are illegal
    always_comb begin
        s_phase  = 3'd0;
        s_in_map = 1'b1;
        case (s_dff_q)
            4'b0000: s_phase = 3'd0;
            4'b0001: s_phase = 3'd1;
            4'b0011: s_phase = 3'd2;
            4'b0111: s_phase = 3'd3;
            4'b1111: s_phase = 3'd4;
            4'b1110: s_phase = 3'd5;
            4'b1100: s_phase = 3'd6;
            4'b1000: s_phase = 3'd7;
            default: s_in_map = 1'b0;
        endcase
    end

    // Classify the held sample, check the transition and compute next state and outputs.
    // ERR_CLR rides along with its sample, so clear-versus-count is settled on one sample.
    always_comb begin
        s_valid_d      = 1'b1;
        s_dff_d        = DFF4;
        s_dec_d        = Decoded8;
        s_hold_d       = HOLD;
        s_clr_d        = ERR_CLR;

        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        prev_legal_d   = prev_legal_q;
        prev_phase_d   = prev_phase_q;
        prev_hold_d    = prev_hold_q;
        phase_d        = phase_q;
        phase_valid_d  = phase_valid_q;
        err_d          = 1'b0;
        err_code_d     = CODE_NONE;
        err_count_d    = err_count_q;
        wrap_d         = 1'b0;

        expected_phase = prev_phase_q + {2'b00, ~prev_hold_q};
        s_legal        = s_in_map && (s_dec_q == (8'd1 << s_phase));

        if (!s_in_map) begin
            code = CODE_ILLEGAL;
        end else if (!s_legal) begin
            code = CODE_MISMATCH;
        end else if (prev_legal_q && (s_phase != expected_phase)) begin
            code = CODE_SKIP;
        end else begin
            code = CODE_NONE;
        end

        fault     = (code != CODE_NONE);
        good_step = s_legal && prev_legal_q && (s_phase == expected_phase);

        if (s_valid_q) begin
            prev_legal_d = s_legal;
            if (s_legal) begin
                prev_phase_d = s_phase;
                prev_hold_d  = s_hold_q;
            end

            if (fault) begin
                phase_valid_d = 1'b0;
            end else begin
                phase_d       = s_phase;
                phase_valid_d = 1'b1;
            end

            err_d      = fault;
            err_code_d = code;

            case (state_q)
                ACQUIRE: begin
                    if (good_step) begin
                        if (good_cnt_q == 4'(LOCK_COUNT - 1)) begin
                            state_d    = LOCK;
                            good_cnt_d = 4'd0;
                        end else begin
                            good_cnt_d = good_cnt_q + 4'd1;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
                LOCK: begin
                    if (fault) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = 4'd0;
                        if (!(&err_count_q)) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end else if (good_step && (prev_phase_q == 3'd7) &&
                                 (s_phase == 3'd0) && !prev_hold_q) begin
                        wrap_d = 1'b1;
                    end
                end
                default: state_d = ACQUIRE;
            endcase

            if (s_clr_q) begin
                err_count_d = '0;
            end
        end
    end

    // Register the sample stage and all checker state; reset wins over everything
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_valid_q     <= 1'b0;
            s_dff_q       <= 4'd0;
            s_dec_q       <= 8'd0;
            s_hold_q      <= 1'b0;
            s_clr_q       <= 1'b0;
            state_q       <= ACQUIRE;
            good_cnt_q    <= 4'd0;
            prev_legal_q  <= 1'b0;
            prev_phase_q  <= 3'd0;
            prev_hold_q   <= 1'b0;
            phase_q       <= 3'd0;
            phase_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= CODE_NONE;
            err_count_q   <= '0;
            wrap_q        <= 1'b0;
        end else begin
            s_valid_q     <= s_valid_d;
            s_dff_q       <= s_dff_d;
            s_dec_q       <= s_dec_d;
            s_hold_q      <= s_hold_d;
            s_clr_q       <= s_clr_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            prev_legal_q  <= prev_legal_d;
            prev_phase_q  <= prev_phase_d;
            prev_hold_q   <= prev_hold_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_count_q   <= err_count_d;
            wrap_q        <= wrap_d;
        end
    end

    assign PHASE       = phase_q;
    assign PHASE_VALID = phase_valid_q;
    assign LOCKED      = (state_q == LOCK);
    assign ERR         = err_q;
    assign ERR_CODE    = err_code_q;
    assign ERR_COUNT   = err_count_q;
    assign WRAP        = wrap_q;

endmodule
